// File: rtl/PARAMS_pkg.sv
// rtl/PARAMS_pkg.sv - shared core width parameters
package PARAMS_pkg;
    parameter int WD_SIZE        = 32;
    parameter int INSTR_REG_SIZE = 5;
endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - integer register file with write-pending scoreboard
//
// Purpose: holds the integer registers, serves decode's two combinational
// operand reads (with write-back bypass) and stalls issue while a source
// register still has an older write in flight.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   wb_rd_i/wb_data_i/wb_reg_write_i write-back register write (retires a pending write)
//   dec_rs1_i/dec_rs2_i              source indexes, qualified by dec_rs*_used_i
//   dec_issue_i                      decode presents an instruction
//   dec_rd_i/dec_reg_write_i         destination of the issuing instruction
//   rs1_data_o/rs2_data_o            operand values
//   stall_o                          issue blocked this cycle
//   err_o                            sticky retire-without-pending flag
module reg_file_scoreboard #(
    parameter int WD_SIZE        = PARAMS_pkg::WD_SIZE,
    parameter int INSTR_REG_SIZE = PARAMS_pkg::INSTR_REG_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INSTR_REG_SIZE-1:0] wb_rd_i,
    input  logic [WD_SIZE-1:0]        wb_data_i,
    input  logic                      wb_reg_write_i,
    input  logic [INSTR_REG_SIZE-1:0] dec_rs1_i,
    input  logic [INSTR_REG_SIZE-1:0] dec_rs2_i,
    input  logic                      dec_rs1_used_i,
    input  logic                      dec_rs2_used_i,
    input  logic                      dec_issue_i,
    input  logic [INSTR_REG_SIZE-1:0] dec_rd_i,
    input  logic                      dec_reg_write_i,
    output logic [WD_SIZE-1:0]        rs1_data_o,
    output logic [WD_SIZE-1:0]        rs2_data_o,
    output logic                      stall_o,
    output logic                      err_o
);
    localparam int N = 1 << INSTR_REG_SIZE;
    localparam logic [INSTR_REG_SIZE-1:0] ZERO_IDX = '0;

    logic [WD_SIZE-1:0] r_regs [N];
    logic [1:0]         r_cnt  [N];
    logic               r_err;

    logic       w_wb_we;
    logic       w_ret_rs1;
    logic       w_ret_rs2;
    logic       w_ret_rd;
    logic [1:0] w_cnt_rs1;
    logic [1:0] w_cnt_rs2;
    logic [1:0] w_cnt_rd;
    logic       w_hz_rs1;
    logic       w_hz_rs2;
    logic       w_sat_rd;
    logic       w_accept;
    logic       w_alloc_en;

    // A write to x0 is neither stored nor counted, so it never retires anything.
    assign w_wb_we = wb_reg_write_i && (wb_rd_i != ZERO_IDX);

    assign w_ret_rs1 = w_wb_we && (wb_rd_i == dec_rs1_i);
    assign w_ret_rs2 = w_wb_we && (wb_rd_i == dec_rs2_i);
    assign w_ret_rd  = w_wb_we && (wb_rd_i == dec_rd_i);

    assign w_cnt_rs1 = r_cnt[dec_rs1_i];
    assign w_cnt_rs2 = r_cnt[dec_rs2_i];
    assign w_cnt_rd  = r_cnt[dec_rd_i];

    // One pending write that retires this cycle is served by the bypass;
    // two or more means the retiring value is already stale for this reader.
    assign w_hz_rs1 = (dec_rs1_i != ZERO_IDX) &&
                      (w_cnt_rs1[1] || ((w_cnt_rs1 == 2'd1) && !w_ret_rs1));
    assign w_hz_rs2 = (dec_rs2_i != ZERO_IDX) &&
                      (w_cnt_rs2[1] || ((w_cnt_rs2 == 2'd1) && !w_ret_rs2));

    // A fourth writer would overflow the 2-bit counter unless one retires now.
    assign w_sat_rd = dec_reg_write_i && (dec_rd_i != ZERO_IDX) &&
                      (w_cnt_rd == 2'd3) && !w_ret_rd;

    assign stall_o = dec_issue_i &&
                     ((dec_rs1_used_i && w_hz_rs1) ||
                      (dec_rs2_used_i && w_hz_rs2) ||
                      w_sat_rd);

    assign w_accept   = dec_issue_i && !stall_o;
    assign w_alloc_en = w_accept && dec_reg_write_i && (dec_rd_i != ZERO_IDX);

    assign rs1_data_o = (dec_rs1_i == ZERO_IDX) ? '0 :
                        w_ret_rs1               ? wb_data_i : r_regs[dec_rs1_i];
    assign rs2_data_o = (dec_rs2_i == ZERO_IDX) ? '0 :
                        w_ret_rs2               ? wb_data_i : r_regs[dec_rs2_i];

    assign err_o = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= 2'd0;
            end
            r_err <= 1'b0;
        end else begin
            if (w_wb_we) begin
                r_regs[wb_rd_i] <= wb_data_i;
            end
            for (int r = 1; r < N; r++) begin
                logic v_alloc;
                logic v_ret;
                v_alloc = w_alloc_en && (dec_rd_i == INSTR_REG_SIZE'(r));
                v_ret   = w_wb_we && (wb_rd_i == INSTR_REG_SIZE'(r));
                if (v_alloc && !v_ret) begin
                    r_cnt[r] <= r_cnt[r] + 2'd1;
                end else if (v_ret && !v_alloc) begin
                    if (r_cnt[r] == 2'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt[r] <= r_cnt[r] - 2'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        wb_reg_write_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic        dec_rs1_used_i;
    logic        dec_rs2_used_i;
    logic        dec_issue_i;
    logic [4:0]  dec_rd_i;
    logic        dec_reg_write_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        stall_o;
    logic        err_o;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .wb_reg_write_i  (wb_reg_write_i),
        .dec_rs1_i       (dec_rs1_i),
        .dec_rs2_i       (dec_rs2_i),
        .dec_rs1_used_i  (dec_rs1_used_i),
        .dec_rs2_used_i  (dec_rs2_used_i),
        .dec_issue_i     (dec_issue_i),
        .dec_rd_i        (dec_rd_i),
        .dec_reg_write_i (dec_reg_write_i),
        .rs1_data_o      (rs1_data_o),
        .rs2_data_o      (rs2_data_o),
        .stall_o         (stall_o),
        .err_o           (err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register values and number of in-flight writes per register.
    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;
    bit          last_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_ret(input int r);
        return wb_reg_write_i && (int'(wb_rd_i) == r) && (r != 0);
    endfunction

    function automatic bit m_hz(input int rs);
        if (rs == 0) return 1'b0;
        return (m_pend[rs] >= 2) || (m_pend[rs] == 1 && !m_ret(rs));
    endfunction

    function automatic bit m_stall();
        if (!dec_issue_i) return 1'b0;
        return (dec_rs1_used_i && m_hz(int'(dec_rs1_i))) ||
               (dec_rs2_used_i && m_hz(int'(dec_rs2_i))) ||
               (dec_reg_write_i && dec_rd_i != 0 && m_pend[dec_rd_i] == 3 && !m_ret(int'(dec_rd_i)));
    endfunction

    function automatic logic [31:0] m_read(input int rs);
        if (rs == 0) return 32'h0;
        if (m_ret(rs)) return wb_data_i;
        return m_regs[rs];
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'h0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic idle();
        wb_rd_i = 0; wb_data_i = 0; wb_reg_write_i = 0;
        dec_rs1_i = 0; dec_rs2_i = 0; dec_rs1_used_i = 0; dec_rs2_used_i = 0;
        dec_issue_i = 0; dec_rd_i = 0; dec_reg_write_i = 0;
    endtask

    task automatic model_check(input string tag);
        #2;
        chk({tag, ".rs1"},   rs1_data_o, m_read(int'(dec_rs1_i)));
        chk({tag, ".rs2"},   rs2_data_o, m_read(int'(dec_rs2_i)));
        chk({tag, ".stall"}, {31'h0, stall_o}, {31'h0, m_stall()});
        chk({tag, ".err"},   {31'h0, err_o}, {31'h0, m_err});
    endtask

    // Advance one clock and apply the same rules to the model.
    task automatic tick();
        bit st;
        bit acc;
        int rd;
        int wr;
        st  = m_stall();
        acc = dec_issue_i && !st;
        rd  = int'(dec_rd_i);
        wr  = int'(wb_rd_i);
        @(posedge clk);
        if (!reset) begin
            bit alloc_any;
            alloc_any = acc && dec_reg_write_i && rd != 0;
            if (wb_reg_write_i && wr != 0) begin
                m_regs[wr] = wb_data_i;
                if (!(alloc_any && rd == wr)) begin
                    if (m_pend[wr] == 0) m_err = 1'b1;
                    else m_pend[wr]--;
                end
            end
            if (alloc_any && !(wb_reg_write_i && wr == rd)) m_pend[rd]++;
        end
        last_stall = st;
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        dec_issue_i = 1; dec_reg_write_i = 1; dec_rd_i = rd;
    endtask

    task automatic retire(input logic [4:0] rd, input logic [31:0] d);
        wb_reg_write_i = 1; wb_rd_i = rd; wb_data_i = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        m_clear();
        last_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset, then read.
        dec_issue_i = 1; dec_rs1_i = 5; dec_rs2_i = 0; dec_rs1_used_i = 1; dec_rs2_used_i = 1;
        model_check("reset");
        chk("reset.x5", rs1_data_o, 32'h0);
        chk("reset.x0", rs2_data_o, 32'h0);
        chk("reset.stall", {31'h0, stall_o}, 32'h0);
        chk("reset.err", {31'h0, err_o}, 32'h0);
        tick();

        // Write then read, with the write allocated first so no underflow.
        idle(); issue_wr(3); model_check("alloc3"); tick();
        idle(); retire(3, 32'hDEADBEEF); dec_rs1_i = 3;
        model_check("bypass");
        chk("bypass.x3", rs1_data_o, 32'hDEADBEEF);
        tick();
        idle(); dec_rs1_i = 3;
        model_check("array");
        chk("array.x3", rs1_data_o, 32'hDEADBEEF);
        tick();

        // RAW stall on x7.
        idle(); issue_wr(7); model_check("raw.alloc"); tick();
        idle(); dec_issue_i = 1; dec_rs2_i = 7; dec_rs2_used_i = 1;
        for (int k = 0; k < 2; k++) begin
            model_check("raw.hold");
            chk("raw.stall", {31'h0, stall_o}, 32'h1);
            tick();
        end
        retire(7, 32'h0BADF00D);
        model_check("raw.ret");
        chk("raw.release", {31'h0, stall_o}, 32'h0);
        chk("raw.data", rs2_data_o, 32'h0BADF00D);
        tick();

        // Double allocation on x4.
        idle(); issue_wr(4); model_check("dbl.a1"); tick();
        model_check("dbl.a2"); tick();
        idle(); dec_issue_i = 1; dec_rs1_i = 4; dec_rs1_used_i = 1;
        retire(4, 32'h11111111);
        model_check("dbl.ret1");
        chk("dbl.stall1", {31'h0, stall_o}, 32'h1);
        tick();
        wb_reg_write_i = 0;
        model_check("dbl.wait");
        chk("dbl.stall2", {31'h0, stall_o}, 32'h1);
        tick();
        retire(4, 32'h22222222);
        model_check("dbl.ret2");
        chk("dbl.release", {31'h0, stall_o}, 32'h0);
        chk("dbl.data", rs1_data_o, 32'h22222222);
        tick();

        // Saturation on x9.
        idle(); issue_wr(9);
        for (int k = 0; k < 3; k++) begin
            model_check("sat.alloc");
            tick();
        end
        model_check("sat.full");
        chk("sat.stall", {31'h0, stall_o}, 32'h1);
        tick();
        retire(9, 32'h99);
        model_check("sat.ret");
        chk("sat.accept", {31'h0, stall_o}, 32'h0);
        tick();
        wb_reg_write_i = 0;
        model_check("sat.still3");
        chk("sat.stall3", {31'h0, stall_o}, 32'h1);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            retire(9, 32'h90 + k);
            model_check("sat.drain");
            tick();
        end

        // x0 and underflow.
        idle(); retire(0, 32'h1234); dec_rs1_i = 0;
        model_check("x0.wr");
        chk("x0.bypass", rs1_data_o, 32'h0);
        tick();
        idle(); dec_rs1_i = 0; dec_issue_i = 1; dec_rs1_used_i = 1;
        model_check("x0.rd");
        chk("x0.rd", rs1_data_o, 32'h0);
        chk("x0.err", {31'h0, err_o}, 32'h0);
        tick();
        idle(); retire(12, 32'h12);
        model_check("uf.ret"); tick();
        idle();
        chk("uf.err", {31'h0, err_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            model_check("uf.sticky"); tick();
        end
        chk("uf.err_sticky", {31'h0, err_o}, 32'h1);

        // Asynchronous reset between edges clears state and the error flag.
        #2 reset = 1'b1;
        m_clear();
        #1;
        chk("areset.err", {31'h0, err_o}, 32'h0);
        dec_rs1_i = 3;
        model_check("areset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized traffic with decode holding stalled instructions.
        idle();
        for (int i = 0; i < 600; i++) begin
            int r;
            if (!(last_stall && dec_issue_i)) begin
                dec_issue_i     = ($urandom_range(0, 3) != 0);
                dec_rs1_i       = 5'($urandom_range(0, 7));
                dec_rs2_i       = 5'($urandom_range(0, 7));
                dec_rs1_used_i  = $urandom_range(0, 1);
                dec_rs2_used_i  = $urandom_range(0, 1);
                dec_rd_i        = 5'($urandom_range(0, 7));
                dec_reg_write_i = ($urandom_range(0, 3) != 0);
            end
            r = $urandom_range(0, 7);
            wb_reg_write_i = (m_pend[r] > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 31) == 0);
            wb_rd_i   = 5'(r);
            wb_data_i = $urandom;
            model_check("rand");
            tick();
            if (i == 300) begin
                idle();
                reset = 1'b1;
                m_clear();
                model_check("rand.reset");
                tick();
                reset = 1'b0;
                last_stall = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Integer register file and write-pending scoreboard. It is the receiving end of the write-back stage's register-write interface (`rd`, write data, write enable). Decode reads operands through it, and it stalls decode while a source register still has an older in-flight write that has not reached write-back. It sits between the decode stage and the write-back stage.

## Interface
- `WD_SIZE`, default `PARAMS_pkg::WD_SIZE` (32): register data width.
- `INSTR_REG_SIZE`, default `PARAMS_pkg::INSTR_REG_SIZE` (5): register index width; 2^INSTR_REG_SIZE registers.
- `clk`, in, 1: the only clock. All state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `wb_rd_i`, in, INSTR_REG_SIZE: destination register from write-back.
- `wb_data_i`, in, WD_SIZE: write data from write-back.
- `wb_reg_write_i`, in, 1: write-back write enable.
- `dec_rs1_i`, in, INSTR_REG_SIZE: source register 1 index.
- `dec_rs2_i`, in, INSTR_REG_SIZE: source register 2 index.
- `dec_rs1_used_i`, in, 1: the instruction reads rs1.
- `dec_rs2_used_i`, in, 1: the instruction reads rs2.
- `dec_issue_i`, in, 1: decode presents an instruction for issue.
- `dec_rd_i`, in, INSTR_REG_SIZE: destination of the issuing instruction.
- `dec_reg_write_i`, in, 1: the issuing instruction writes `dec_rd_i`.
- `rs1_data_o`, out, WD_SIZE: operand 1 value.
- `rs2_data_o`, out, WD_SIZE: operand 2 value.
- `stall_o`, out, 1: issue blocked this cycle.
- `err_o`, out, 1: sticky scoreboard underflow flag.

## Operation
- **Storage.**
  - 2^INSTR_REG_SIZE registers of WD_SIZE bits.
  - Register 0 reads as 0 at all times. Writes to register 0 are discarded and never touch its counter.
- **Write.** When `wb_reg_write_i`=1 and `wb_rd_i`≠0, `regs[wb_rd_i]` ← `wb_data_i` at the next edge.
- **Read.**
  - Reads are combinational.
  - Write-through bypass: if `wb_reg_write_i`=1, `wb_rd_i`≠0 and `wb_rd_i` equals the read index, the output is `wb_data_i` instead of the array value.
- **Scoreboard counters.**
  - Each register 1..N-1 has a 2-bit outstanding-write counter `cnt[r]`, range 0..3.
  - `retire(r)` = `wb_reg_write_i` & `wb_rd_i`=r & r≠0.
  - `accept` = `dec_issue_i` & ~`stall_o`.
  - `alloc(r)` = `accept` & `dec_reg_write_i` & `dec_rd_i`=r & r≠0.
- **Counter update, per register r, at the edge.**
  - alloc and retire together: unchanged.
  - alloc only: +1.
  - retire only: −1.
  - Retire with `cnt[r]`=0: counter stays 0 and `err_o` is set (sticky until reset).
- **Source hazard.** `hz(rs)` = rs≠0 & (`cnt[rs]`≥2, or `cnt[rs]`=1 & ~`retire(rs)`). A single outstanding write that retires this cycle is covered by the bypass and does not stall.
- **Stall.** `stall_o` = `dec_issue_i` & ((`dec_rs1_used_i` & `hz(dec_rs1_i)`) | (`dec_rs2_used_i` & `hz(dec_rs2_i)`) | (`dec_reg_write_i` & `dec_rd_i`≠0 & `cnt[dec_rd_i]`=3 & ~`retire(dec_rd_i)`)).
- When `dec_issue_i`=0, `stall_o`=0.
- A stalled instruction allocates nothing. Decode holds its inputs until `stall_o`=0.

## Timing
- **Reset values.** All registers 0, all counters 0, `err_o`=0.
- While `reset` is high:
  - `stall_o` and the data outputs follow the combinational rules above, with zero state.
  - Write-back writes and allocations are ignored.
- Reset asserted mid-operation clears all state asynchronously. Outstanding writes are forgotten, and a later retire of them sets `err_o`; the pipeline is flushed together with this block.
- **Write-to-read latency.**
  - Same cycle via the bypass.
  - From the array one cycle after the write edge.
- **Counter latency.**
  - An alloc is visible to `stall_o` in the cycle after the accepting edge.
  - A retire affects `stall_o` combinationally in its own cycle.
- `stall_o` depends combinationally on the `dec_*` inputs, the `wb_*` inputs and the counters. There is no path from `stall_o` back into these inputs.

## Test plan
- **Reset, then read.** Reset, then read x5 and x0 → both read 0; `stall_o`=0; `err_o`=0.
- **Write then read.**
  - Write-back writes x3=0xDEADBEEF; in the same cycle decode reads rs1=x3 → `rs1_data_o`=0xDEADBEEF (bypass).
  - Next cycle, with write-back idle → still 0xDEADBEEF.
- **RAW stall.**
  - Issue an instruction with rd=x7 (write), then one reading rs2=x7 → `stall_o`=1 until write-back retires x7.
  - In the retire cycle, `stall_o`=0 and `rs2_data_o` equals `wb_data_i`.
- **Double allocation.**
  - Issue writes to x4 twice (`cnt`=2), then one reading x4 → stalls through the first retire (`cnt` becomes 1).
  - Released in the cycle of the second retire.
- **Saturation.**
  - Three allocations to x9, then a fourth writer to x9 → `stall_o`=1.
  - Retire x9 in the same cycle → accepted, `cnt` stays 3.
- **x0 and underflow.**
  - Write 0x1234 to x0 → x0 still reads 0; no counter change.
  - Retire x12 with `cnt`=0 → `err_o`=1 and stays 1 until `reset`.
